// File: rtl/tile_slide_if.sv
// tile_slide_if: start/busy/done handshake and board buses between the game core and tile_slide_engine.
interface tile_slide_if #(
    parameter int N = 4,
    parameter int TILE_W = 12,
    parameter int SCORE_W = 20
);
    logic start;
    logic [3:0] direction;
    logic [N-1:0][N-1:0][TILE_W-1:0] board_in;
    logic [N-1:0][N-1:0][TILE_W-1:0] board_out;
    logic [SCORE_W-1:0] score_update;
    logic moved;
    logic busy;
    logic done;
    logic win;
    modport master (
        output start, direction, board_in,
        input  board_out, score_update, moved, busy, done, win
    );
    modport slave (
        input  start, direction, board_in,
        output board_out, score_update, moved, busy, done, win
    );
endinterface

// File: rtl/tile_slide_engine.sv
// tile_slide_engine: NxN 2048 slide-and-merge, one line per cycle under start/busy/done.
// Define TILE_SLIDE_WIN_DETECT_EN to enable the sticky win flag (otherwise win is tied low).
module tile_slide_engine #(
    parameter int N = 4,
    parameter int TILE_W = 12,
    parameter int SCORE_W = 20,
    parameter int WIN_VALUE = 2048
) (
    input  logic clk,
    input  logic rst,
    tile_slide_if.slave bus
);
    localparam int IW = $clog2(N);
    localparam int AW = (SCORE_W > TILE_W ? SCORE_W : TILE_W) + 1;
    localparam logic [AW-1:0] SMAX = AW'({SCORE_W{1'b1}});
    typedef logic [N-1:0][N-1:0][TILE_W-1:0] board_t;
    typedef enum logic [1:0] {IDLE, LINE, FINISH} state_t;

    if (N < 2 || WIN_VALUE < 1) begin : g_param_check
        $error("tile_slide_engine: N must be >= 2 and WIN_VALUE positive");
    end

    state_t state;
    logic [3:0] dir;
    board_t brd, res, res_n, board_out;
    logic [IW-1:0] idx;
    logic [SCORE_W-1:0] acc, acc_n, score_update;
    logic moved, busy, done, dir_ok;
    logic [N-1:0][TILE_W-1:0] ln, m;
    logic [N:0][TILE_W-1:0] c;
`ifdef TILE_SLIDE_WIN_DETECT_EN
    localparam logic [TILE_W-1:0] WIN_TILE = TILE_W'(WIN_VALUE);
    logic hit, hit_n, win;
`endif

    assign dir_ok = $onehot(dir);

    // Line is gathered leading-edge first so the merge scan is the same for all directions;
    // c has one spare zero slot so the pair compare never runs off the end.
    always_comb begin
        int k;
        int j;
        logic skip;
        logic [AW-1:0] t;
        ln = '0;
        c = '0;
        m = '0;
        res_n = res;
        k = 0;
        j = 0;
        skip = 1'b0;
        t = AW'(acc);
`ifdef TILE_SLIDE_WIN_DETECT_EN
        hit_n = hit;
`endif
        for (int i = 0; i < N; i++)
            ln[i] = dir[0] ? brd[i][idx] : dir[1] ? brd[N-1-i][idx] : dir[2] ? brd[idx][i] : brd[idx][N-1-i];
        for (int i = 0; i < N; i++)
            if (ln[i] != '0) begin
                c[k] = ln[i];
                k++;
            end
        for (int i = 0; i < N; i++)
            if (skip) skip = 1'b0;
            else if (c[i] != '0) begin
                if (c[i] == c[i+1] && !c[i][TILE_W-1]) begin
                    m[j] = c[i] << 1;
                    t = (t + AW'(m[j]) > SMAX) ? SMAX : t + AW'(m[j]);
`ifdef TILE_SLIDE_WIN_DETECT_EN
                    hit_n = hit_n | (dir_ok && m[j] == WIN_TILE);
`endif
                    skip = 1'b1;
                end else m[j] = c[i];
                j++;
            end
        if (dir_ok)
            for (int i = 0; i < N; i++)
                if (dir[0]) res_n[i][idx] = m[i];
                else if (dir[1]) res_n[N-1-i][idx] = m[i];
                else if (dir[2]) res_n[idx][i] = m[i];
                else res_n[idx][N-1-i] = m[i];
        acc_n = dir_ok ? t[SCORE_W-1:0] : acc;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            dir <= '0;
            brd <= '0;
            res <= '0;
            idx <= '0;
            acc <= '0;
            board_out <= '0;
            score_update <= '0;
            moved <= 1'b0;
            busy <= 1'b0;
            done <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: if (bus.start) begin
                    state <= LINE;
                    dir <= bus.direction;
                    brd <= bus.board_in;
                    res <= bus.board_in;
                    idx <= '0;
                    acc <= '0;
                    busy <= 1'b1;
                end
                LINE: begin
                    res <= res_n;
                    acc <= acc_n;
                    idx <= idx + 1'b1;
                    if (idx == IW'(N-1)) begin
                        state <= FINISH;
                        board_out <= res_n;
                        score_update <= acc_n;
                        moved <= res_n != brd;
                        busy <= 1'b0;
                        done <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef TILE_SLIDE_WIN_DETECT_EN
    // win is sticky across moves; only reset clears it
    always_ff @(posedge clk) begin
        if (rst) begin
            hit <= 1'b0;
            win <= 1'b0;
        end else if (state == IDLE && bus.start) hit <= 1'b0;
        else if (state == LINE) begin
            hit <= hit_n;
            if (idx == IW'(N-1)) win <= win | hit_n;
        end
    end
    assign bus.win = win;
`else
    assign bus.win = 1'b0;
`endif

    assign bus.board_out = board_out;
    assign bus.score_update = score_update;
    assign bus.moved = moved;
    assign bus.busy = busy;
    assign bus.done = done;
endmodule

// File: tb/tb_tile_slide_engine.sv
// tb_tile_slide_engine: directed vector table plus handshake, reset-abort, win and saturation sequences.
module tb_tile_slide_engine;
    localparam int N = 4;
    localparam int TW = 12;
    localparam int SW = 20;
    typedef logic [N-1:0][TW-1:0] row_t;
    typedef logic [N-1:0][N-1:0][TW-1:0] board_t;
    typedef logic [N-1:0][N-1:0][3:0] sboard_t;
    typedef struct {
        string name;
        logic [3:0] dir;
        board_t bin;
        board_t bexp;
        logic [SW-1:0] score;
        logic moved;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    int applied = 0;
    int errors = 0;
    int ndone;
    logic exp_win;
    vec_t tbl[10];

    always #5 clk = ~clk;

    tile_slide_if #(.N(N), .TILE_W(TW), .SCORE_W(SW)) bus();
    tile_slide_if #(.N(N), .TILE_W(4), .SCORE_W(4)) sbus();
    tile_slide_engine #(.N(N), .TILE_W(TW), .SCORE_W(SW), .WIN_VALUE(2048)) dut (.clk(clk), .rst(rst), .bus(bus));
    tile_slide_engine #(.N(N), .TILE_W(4), .SCORE_W(4)) sdut (.clk(clk), .rst(rst), .bus(sbus));

    function automatic row_t r(int a, int b, int c, int d);
        return {TW'(d), TW'(c), TW'(b), TW'(a)};
    endfunction

    function automatic board_t bd(row_t r0, row_t r1, row_t r2, row_t r3);
        return {r3, r2, r1, r0};
    endfunction

    function automatic sboard_t sb(int a, int b, int c, int d);
        sboard_t x = '0;
        x[0] = {4'(d), 4'(c), 4'(b), 4'(a)};
        return x;
    endfunction

    task automatic chk(string name, logic [255:0] act, logic [255:0] exp);
        applied++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic run(string name, logic [3:0] dir, board_t bin, board_t bexp, logic [SW-1:0] sc, logic mv);
        @(negedge clk);
        bus.start = 1'b1;
        bus.direction = dir;
        bus.board_in = bin;
        @(negedge clk);
        bus.start = 1'b0;
        bus.board_in = ~bin;
        for (int cyc = 1; cyc <= N + 1; cyc++) begin
            chk({name, " busy"}, 256'(bus.busy), 256'(cyc <= N));
            chk({name, " done"}, 256'(bus.done), 256'(cyc == N + 1));
            if (cyc <= N) @(negedge clk);
        end
        chk({name, " board"}, 256'(bus.board_out), 256'(bexp));
        chk({name, " score"}, 256'(bus.score_update), 256'(sc));
        chk({name, " moved"}, 256'(bus.moved), 256'(mv));
        @(negedge clk);
        chk({name, " done drop"}, 256'(bus.done), 256'(0));
    endtask

    task automatic run_small(string name, sboard_t bin, sboard_t bexp, logic [3:0] sc);
        logic seen = 1'b0;
        @(negedge clk);
        sbus.start = 1'b1;
        sbus.direction = 4'b1000;
        sbus.board_in = bin;
        @(negedge clk);
        sbus.start = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            if (sbus.done) seen = 1'b1;
            else @(negedge clk);
        end
        chk({name, " done seen"}, 256'(seen), 256'(1));
        chk({name, " board"}, 256'(sbus.board_out), 256'(bexp));
        chk({name, " score"}, 256'(sbus.score_update), 256'(sc));
    endtask

    initial begin
`ifdef TILE_SLIDE_WIN_DETECT_EN
        exp_win = 1'b1;
`else
        exp_win = 1'b0;
`endif
        tbl[0] = '{"left", 4'b0100, bd(r(2,2,2,2), r(4,4,8,0), r(0,0,0,2), r(2,0,2,4)),
                   bd(r(4,4,0,0), r(8,8,0,0), r(2,0,0,0), r(4,4,0,0)), 20'd20, 1'b1};
        tbl[1] = '{"up still", 4'b0001, bd(r(2,0,0,0), r(4,0,0,0), r(8,0,0,0), r(16,0,0,0)),
                   bd(r(2,0,0,0), r(4,0,0,0), r(8,0,0,0), r(16,0,0,0)), 20'd0, 1'b0};
        tbl[2] = '{"right", 4'b1000, bd(r(2,0,0,2), r(0,2,4,4), r(0,0,0,0), r(0,0,0,8)),
                   bd(r(0,0,0,4), r(0,0,2,8), r(0,0,0,0), r(0,0,0,8)), 20'd12, 1'b1};
        tbl[3] = '{"down", 4'b0010, bd(r(0,2,0,0), r(0,2,0,8), r(0,4,0,0), r(0,4,0,0)),
                   bd(r(0,0,0,0), r(0,0,0,0), r(0,4,0,0), r(0,8,0,8)), 20'd12, 1'b1};
        tbl[4] = '{"dir 0011", 4'b0011, tbl[0].bin, tbl[0].bin, 20'd0, 1'b0};
        tbl[5] = '{"dir 0000", 4'b0000, tbl[2].bin, tbl[2].bin, 20'd0, 1'b0};
        tbl[6] = '{"left empty", 4'b0100, '0, '0, 20'd0, 1'b0};
        tbl[7] = '{"left msb", 4'b0100, bd(r(2,4,2,4), r(0,0,0,0), r(8,0,0,8), r(2048,2048,0,0)),
                   bd(r(2,4,2,4), r(0,0,0,0), r(16,0,0,0), r(2048,2048,0,0)), 20'd16, 1'b1};
        tbl[8] = '{"up three", 4'b0001, bd(r(2,0,0,4), r(2,0,0,0), r(2,0,0,4), r(0,0,0,4)),
                   bd(r(4,0,0,8), r(2,0,0,4), r(0,0,0,0), r(0,0,0,0)), 20'd12, 1'b1};
        tbl[9] = '{"dir 1100", 4'b1100, tbl[8].bin, tbl[8].bin, 20'd0, 1'b0};

        rst = 1'b1;
        bus.start = 1'b0;
        bus.direction = '0;
        bus.board_in = '0;
        sbus.start = 1'b0;
        sbus.direction = '0;
        sbus.board_in = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("reset board", 256'(bus.board_out), 256'(0));
        chk("reset score", 256'(bus.score_update), 256'(0));
        chk("reset moved", 256'(bus.moved), 256'(0));
        chk("reset busy", 256'(bus.busy), 256'(0));
        chk("reset done", 256'(bus.done), 256'(0));
        chk("reset win", 256'(bus.win), 256'(0));

        for (int i = 0; i < 10; i++)
            run(tbl[i].name, tbl[i].dir, tbl[i].bin, tbl[i].bexp, tbl[i].score, tbl[i].moved);
        chk("no win yet", 256'(bus.win), 256'(0));

        // second start while busy must be dropped
        @(negedge clk);
        bus.start = 1'b1;
        bus.direction = tbl[0].dir;
        bus.board_in = tbl[0].bin;
        @(negedge clk);
        bus.start = 1'b0;
        @(negedge clk);
        bus.start = 1'b1;
        bus.direction = 4'b0001;
        bus.board_in = tbl[2].bin;
        @(negedge clk);
        bus.start = 1'b0;
        ndone = 0;
        for (int i = 0; i < 12; i++) begin
            if (bus.done) ndone++;
            @(negedge clk);
        end
        chk("restart done count", 256'(ndone), 256'(1));
        chk("restart board", 256'(bus.board_out), 256'(tbl[0].bexp));
        chk("restart score", 256'(bus.score_update), 256'(20));

        run("win down", 4'b0010, bd(r(0,0,0,0), r(0,0,0,0), r(1024,0,0,0), r(1024,0,0,0)),
            bd(r(0,0,0,0), r(0,0,0,0), r(0,0,0,0), r(2048,0,0,0)), 20'd2048, 1'b1);
        chk("win set", 256'(bus.win), 256'(exp_win));
        run("win hold", 4'b0100, bd(r(0,0,0,0), r(0,0,0,0), r(0,0,0,0), r(2048,0,0,0)),
            bd(r(0,0,0,0), r(0,0,0,0), r(0,0,0,0), r(2048,0,0,0)), 20'd0, 1'b0);
        chk("win sticky", 256'(bus.win), 256'(exp_win));

        run_small("small msb", sb(8,8,4,4), sb(0,8,8,8), 4'd8);
        run_small("small sat", sb(4,4,4,4), sb(0,0,8,8), 4'd15);

        // reset on cycle 3 aborts the move without a done pulse
        @(negedge clk);
        bus.start = 1'b1;
        bus.direction = tbl[0].dir;
        bus.board_in = tbl[0].bin;
        @(negedge clk);
        bus.start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        ndone = 0;
        for (int i = 0; i < 8; i++) begin
            if (bus.done) ndone++;
            @(negedge clk);
        end
        chk("abort done count", 256'(ndone), 256'(0));
        chk("abort board", 256'(bus.board_out), 256'(0));
        chk("abort score", 256'(bus.score_update), 256'(0));
        chk("abort moved", 256'(bus.moved), 256'(0));
        chk("abort busy", 256'(bus.busy), 256'(0));
        chk("abort win", 256'(bus.win), 256'(0));

        $display("== %0d vectors applied, %0d miscompares ==", applied, errors);
        $finish;
    end
endmodule
